wr_chan_sched: RTL and testbench

WR_CHAN_SCHED -- requirements
Module: wr_chan_sched

---
 rtl/wr_chan_sched.sv | 132 +++++++++++++
 tb/tb_wr_chan_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wr_chan_sched.sv
// wr_chan_sched: AXI write-channel scheduler for two requesters.
// Grants one requester at a time, issues its AW transfer, hands the latched
// line to the write data channel manager and waits for the matching B
// response before acknowledging the requester.
// Optional build macro: WR_CHAN_SCHED_FIXED_PRIO_EN -- when defined,
// requester 0 always wins a tie; otherwise ties are resolved round robin.
module wr_chan_sched #(
  parameter logic [2:0] ID_BASE = 3'b000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   wreq,
  input  logic [63:0]  waddr,
  input  logic [255:0] wdata,
  output logic [1:0]   wack,
  output logic [1:0]   werr,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  awaddr,
  output logic [3:0]   awid,
  output logic [7:0]   awlen,
  output logic         next_rq,
  output logic [3:0]   next_id,
  output logic [127:0] next_wdata,
  input  logic         finish_wd,
  input  logic         bvalid,
  output logic         bready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AWOUT = 2'd1,
    WDAT  = 2'd2,
    BWAIT = 2'd3
  } state_t;

  state_t         state;
  logic           last_idx;    // requester granted most recently
  logic [31:0]    addr_q;
  logic [127:0]   data_q;
  logic [3:0]     id_q;        // {ID_BASE, granted index}
  logic           awvalid_q;
  logic           bready_q;
  logic           next_rq_q;
  logic           pick;        // index that wins arbitration this cycle
  logic           b_done;      // B handshake with the matching ID
  logic           unused_bresp;

  // Only the upper response bit distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign unused_bresp = bresp[0];

  // Arbitration: a lone request wins; a tie goes to the favoured requester.
  always_comb begin
    pick = 1'b0;
`ifdef WR_CHAN_SCHED_FIXED_PRIO_EN
    pick = wreq[1] & ~wreq[0];
`else
    pick = wreq[1] & (~wreq[0] | ~last_idx);
`endif
  end

  // Response completion and per-requester acknowledge/error decode.
  always_comb begin
    b_done = bready_q & bvalid & (bid == id_q);
    wack   = '0;
    werr   = '0;
    if (b_done) begin
      wack[id_q[0]] = 1'b1;
      werr[id_q[0]] = bresp[1];
    end
  end

  // Transaction FSM with registered channel outputs and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_idx  <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      id_q      <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      next_rq_q <= 1'b0;
    end else begin
      next_rq_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|wreq) begin
            last_idx  <= pick;
            addr_q    <= pick ? waddr[63:32]   : waddr[31:0];
            data_q    <= pick ? wdata[255:128] : wdata[127:0];
            id_q      <= {ID_BASE, pick};
            awvalid_q <= 1'b1;
            state     <= AWOUT;
          end
        end
        AWOUT: begin
          if (awvalid_q && awready) begin
            awvalid_q <= 1'b0;
            next_rq_q <= 1'b1;
            state     <= WDAT;
          end
        end
        WDAT: begin
          if (finish_wd) begin
            bready_q <= 1'b1;
            state    <= BWAIT;
          end
        end
        BWAIT: begin
          if (b_done) begin
            bready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign awvalid    = awvalid_q;
  assign awaddr     = addr_q;
  assign awid       = id_q;
  assign awlen      = 8'd3;
  assign next_rq    = next_rq_q;
  assign next_id    = id_q;
  assign next_wdata = data_q;
  assign bready     = bready_q;

endmodule

// File: tb/tb_wr_chan_sched.sv
// Directed self-checking bench for wr_chan_sched (ID_BASE overridden to 3'b101).
module tb_wr_chan_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   wreq = '0;
  logic [63:0]  waddr = '0;
  logic [255:0] wdata = '0;
  logic [1:0]   wack, werr;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [31:0]  awaddr;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic         next_rq;
  logic [3:0]   next_id;
  logic [127:0] next_wdata;
  logic         finish_wd = 1'b0;
  logic         bvalid = 1'b0;
  logic         bready;
  logic [3:0]   bid = '0;
  logic [1:0]   bresp = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wr_chan_sched #(.ID_BASE(3'b101)) dut (
    .clk(clk), .rst_n(rst_n), .wreq(wreq), .waddr(waddr), .wdata(wdata),
    .wack(wack), .werr(werr), .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .next_rq(next_rq),
    .next_id(next_id), .next_wdata(next_wdata), .finish_wd(finish_wd),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting from IDLE with wreq already driven.
  task automatic run_txn(input logic idx, input logic [31:0] exp_addr,
                         input logic [127:0] exp_data, input int aw_delay,
                         input logic [1:0] resp, input bit bad_bid_first);
    logic [3:0] exp_id;
    exp_id = {3'b101, idx};
    step();
    chk("aw_valid", awvalid, 1'b1);
    chk("aw_addr", awaddr, exp_addr);
    chk("aw_id", awid, exp_id);
    chk("aw_len", awlen, 8'd3);
    chk("next_wdata", next_wdata, exp_data);
    chk("next_rq_early", next_rq, 1'b0);
    for (int i = 0; i < aw_delay; i++) begin
      finish_wd = (i == 0);
      step();
      finish_wd = 1'b0;
      chk("aw_hold_valid", awvalid, 1'b1);
      chk("aw_hold_addr", awaddr, exp_addr);
      chk("aw_hold_id", awid, exp_id);
      chk("aw_hold_nrq", next_rq, 1'b0);
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("next_rq_pulse", next_rq, 1'b1);
    chk("next_id", next_id, exp_id);
    chk("aw_drop", awvalid, 1'b0);
    chk("bready_wdat", bready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("next_rq_once", next_rq, 1'b0);
      chk("bready_wait", bready, 1'b0);
    end
    finish_wd = 1'b1;
    step();
    finish_wd = 1'b0;
    chk("bready_set", bready, 1'b1);
    chk("wdata_stable", next_wdata, exp_data);
    if (bad_bid_first) begin
      bvalid = 1'b1;
      bid    = exp_id ^ 4'h1;
      bresp  = 2'b00;
      #1;
      chk("bad_bid_wack", wack, 2'b00);
      step();
      chk("bad_bid_stay", bready, 1'b1);
    end
    bvalid = 1'b1;
    bid    = exp_id;
    bresp  = resp;
    #1;
    chk("wack", wack, idx ? 2'b10 : 2'b01);
    chk("werr", werr, resp[1] ? (idx ? 2'b10 : 2'b01) : 2'b00);
    step();
    bvalid = 1'b0;
    #1;
    chk("wack_drop", wack, 2'b00);
    chk("bready_drop", bready, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic exp_idx;
    // Reset state
    #2;
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_awid", awid, 4'h0);
    chk("rst_awlen", awlen, 8'd3);
    chk("rst_next", {next_rq, next_id, bready, wack, werr}, '0);
    chk("rst_wdata", next_wdata, '0);
    #10;
    rst_n = 1'b1;
    step();

    // Single rq0 transaction, immediate awready
    waddr = {32'h0000_9990, 32'h0000_0100};
    wdata = {128'hBBBB_0000_0000_0000_0000_0000_0000_0001,
             128'h4444_3333_2222_1111_0000_0000_0000_00A0};
    wreq  = 2'b01;
    run_txn(1'b0, 32'h100, 128'h4444_3333_2222_1111_0000_0000_0000_00A0, 0, 2'b00, 0);
    wreq = 2'b00;
    step();
    chk("idle_no_regrant", awvalid, 1'b0);

    // Both requesting continuously from reset
    do_reset();
    #1;
    waddr = {32'h0000_3000, 32'h0000_2000};
    wdata = {128'h1111_1111_1111_1111_1111_1111_1111_1111,
             128'h2222_2222_2222_2222_2222_2222_2222_2222};
    wreq  = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef WR_CHAN_SCHED_FIXED_PRIO_EN
      exp_idx = 1'b0;
`else
      exp_idx = k[0];
`endif
      run_txn(exp_idx, exp_idx ? 32'h3000 : 32'h2000,
              exp_idx ? 128'h1111_1111_1111_1111_1111_1111_1111_1111
                      : 128'h2222_2222_2222_2222_2222_2222_2222_2222, 0, 2'b00, 0);
    end
    wreq = 2'b00;
    step();

    // awready held off, stray finish_wd in AWOUT, bid mismatch then SLVERR
    waddr = {32'h0000_5550, 32'h0000_0000};
    wdata = {128'hCAFE_F00D_0000_0000_0000_0000_DEAD_BEEF, 128'h0};
    wreq  = 2'b10;
    run_txn(1'b1, 32'h5550, 128'hCAFE_F00D_0000_0000_0000_0000_DEAD_BEEF, 10, 2'b10, 1);
    wreq = 2'b00;
    step();

    // Reset during WDAT aborts with no acknowledge
    waddr = {32'h0000_7770, 32'h0000_0000};
    wdata = {128'h7777, 128'h0};
    wreq  = 2'b10;
    step();
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("abort_in_wdat", next_rq, 1'b1);
    step();
    bvalid = 1'b1;
    bid    = 4'hB;
    rst_n  = 1'b0;
    #1;
    chk("abort_outs", {awvalid, next_rq, bready, wack, werr, awid, next_id}, '0);
    chk("abort_addr", awaddr, 32'h0);
    chk("abort_data", next_wdata, '0);
    chk("abort_awlen", awlen, 8'd3);
    bvalid = 1'b0;
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_no_wack", wack, 2'b00);
    run_txn(1'b1, 32'h7770, 128'h7777, 0, 2'b00, 0);
    wreq = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
